// File: rtl/adc_fe_pkg.sv
// adc_fe_pkg: shared constants and state types for the ADC front end.
// Overrange counter is built only with ADC_FE_OVR_CNT_EN defined.
package adc_fe_pkg;
  localparam int ADC_W    = 10;
  localparam int AVG_LOG2 = 3;
  localparam int DECIM    = 8192;
  localparam int LLD_INIT = 540;
  localparam int HYST     = 8;
  localparam int STEP_LO  = 4;
  localparam int STEP_HI  = 32;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    RUN
  } fe_state_t;

  typedef enum logic {
    ARMED,
    FIRED
  } trg_state_t;
endpackage

// File: rtl/adc_frontend_boxcar_avg.sv
// boxcar_avg: 2**L-tap running sum of captured samples.
// Part of adc_frontend (optional ADC_FE_OVR_CNT_EN lives in the top).
module boxcar_avg #(
  parameter int W = adc_fe_pkg::ADC_W,
  parameter int L = adc_fe_pkg::AVG_LOG2
) (
  input  logic           CLK,
  input  logic           RSTN,
  input  logic           flush,
  input  logic           cap_v,
  input  logic [W-1:0]   cap_d,
  output logic [W+L-1:0] sum,
  output logic           sum_v,
  output logic           fill_done
);
  import adc_fe_pkg::*;

  localparam int N = 1 << L;

  logic [N-1:0][W-1:0] taps;
  logic [L:0]          cnt;

  assign fill_done = cap_v && !flush &&
                     (cnt == (L+1)'(N-1));

  // shift taps and update the sum on each capture
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      taps  <= '0;
      sum   <= '0;
      cnt   <= '0;
      sum_v <= 1'b0;
    end else if (flush) begin
      taps  <= '0;
      sum   <= '0;
      cnt   <= '0;
      sum_v <= 1'b0;
    end else begin
      sum_v <= 1'b0;
      if (cap_v) begin
        taps  <= {taps[N-2:0], cap_d};
        sum   <= sum + (W+L)'(cap_d)
                     - (W+L)'(taps[N-1]);
        if (cnt != (L+1)'(N))
          cnt <= cnt + (L+1)'(1);
        sum_v <= (cnt >= (L+1)'(N-1));
      end
    end
  end
endmodule

// File: rtl/adc_frontend.sv
// adc_frontend: ADC clocking, boxcar average, decimation, LLD trigger.
// Define ADC_FE_OVR_CNT_EN to build the saturating overrange counter.
module adc_frontend #(
  parameter int ADC_W    = adc_fe_pkg::ADC_W,
  parameter int AVG_LOG2 = adc_fe_pkg::AVG_LOG2,
  parameter int DECIM    = adc_fe_pkg::DECIM,
  parameter int LLD_INIT = adc_fe_pkg::LLD_INIT,
  parameter int HYST     = adc_fe_pkg::HYST
) (
  input  logic             CLK,
  input  logic             RSTN,
  input  logic [ADC_W-1:0] WAVEX,
  input  logic             OVR,
  input  logic             ENABLE,
  input  logic             THR_UP,
  input  logic             THR_DN,
  input  logic             THR_STEP,
  input  logic             OVR_CLR,
  output logic             ADCLK,
  output logic             PWDN,
  output logic             DFS,
  output logic [ADC_W-1:0] AVG,
  output logic             AVG_VALID,
  output logic             DEC_VALID,
  output logic             TRIG,
  output logic [ADC_W-1:0] LLD,
  output logic [15:0]      OVR_CNT
);
  import adc_fe_pkg::*;

  localparam int SW = ADC_W + AVG_LOG2;
  localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam logic [ADC_W-1:0] MAXV   = '1;
  localparam logic [ADC_W-1:0] HYST_V = ADC_W'(HYST);
  localparam logic [ADC_W-1:0] INIT_V = ADC_W'(LLD_INIT);
  localparam logic [DW-1:0]    DLAST  = DW'(DECIM - 1);

  logic [1:0]       ph;
  fe_state_t        state_q, state_d;
  logic             flush;
  logic             cap_v;
  logic [ADC_W-1:0] cap_d;
  logic [SW-1:0]    sum;
  logic             sum_v, fill_done;
  logic [DW-1:0]    dcnt;
  trg_state_t       trg_q, trg_d;
  logic             trig_d;
  logic [ADC_W-1:0] step, rearm;
  logic [ADC_W:0]   lld_up;

  assign ADCLK = ph[1];
  assign PWDN  = ~ENABLE;
  assign DFS   = 1'b0;

  // free-running sample phase, ADC clock is its MSB
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) ph <= 2'd0;
    else       ph <= ph + 2'd1;
  end

  // acquisition state register
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // acquisition next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ENABLE) state_d = FILL;
      FILL:    if (fill_done) state_d = RUN;
      RUN:     state_d = RUN;
      default: state_d = IDLE;
    endcase
    if (!ENABLE) state_d = IDLE;
  end

  // dropping ENABLE kills in-flight work the same cycle
  always_comb begin
    flush = (state_q == IDLE) || !ENABLE;
  end

  // sample WAVEX on phase 0
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      cap_v <= 1'b0;
      cap_d <= '0;
    end else begin
      cap_v <= (ph == 2'd0) && ENABLE;
      if (ph == 2'd0) cap_d <= WAVEX;
    end
  end

  boxcar_avg #(
    .W (ADC_W),
    .L (AVG_LOG2)
  ) u_avg (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .flush     (flush),
    .cap_v     (cap_v),
    .cap_d     (cap_d),
    .sum       (sum),
    .sum_v     (sum_v),
    .fill_done (fill_done)
  );

  // register average and decimated strobe
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      AVG       <= '0;
      AVG_VALID <= 1'b0;
      DEC_VALID <= 1'b0;
      dcnt      <= '0;
    end else begin
      AVG_VALID <= 1'b0;
      DEC_VALID <= 1'b0;
      if (flush) begin
        dcnt <= '0;
      end else if (sum_v && state_q == RUN) begin
        AVG       <= ADC_W'(sum >> AVG_LOG2);
        AVG_VALID <= 1'b1;
        DEC_VALID <= (dcnt == DLAST);
        dcnt      <= (dcnt == DLAST) ? '0
                                      : dcnt + DW'(1);
      end
    end
  end

  assign step   = THR_STEP ? ADC_W'(STEP_HI)
                           : ADC_W'(STEP_LO);
  assign lld_up = {1'b0, LLD} + {1'b0, step};

  // saturating threshold stepping
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      LLD <= INIT_V;
    end else begin
      unique case (1'b1)
        (THR_UP && !THR_DN):
          LLD <= lld_up[ADC_W] ? MAXV
                               : lld_up[ADC_W-1:0];
        (THR_DN && !THR_UP):
          LLD <= (LLD < step) ? '0 : LLD - step;
        default: LLD <= LLD;
      endcase
    end
  end

  assign rearm = (LLD > HYST_V) ? LLD - HYST_V : '0;

  // trigger state register and registered pulse
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      trg_q <= ARMED;
      TRIG  <= 1'b0;
    end else if (flush) begin
      trg_q <= ARMED;
      TRIG  <= 1'b0;
    end else begin
      trg_q <= trg_d;
      TRIG  <= trig_d;
    end
  end

  // trigger next state on each registered average
  always_comb begin
    trg_d  = trg_q;
    trig_d = 1'b0;
    if (AVG_VALID) begin
      unique case (trg_q)
        ARMED: if (AVG >= LLD) begin
          trg_d  = FIRED;
          trig_d = 1'b1;
        end
        FIRED: if (AVG < rearm) trg_d = ARMED;
      endcase
    end
  end

`ifdef ADC_FE_OVR_CNT_EN
  // saturating overrange count, clear has priority
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN)
      OVR_CNT <= '0;
    else if (OVR_CLR)
      OVR_CNT <= '0;
    else if (ph == 2'd0 && ENABLE && OVR &&
             OVR_CNT != 16'hFFFF)
      OVR_CNT <= OVR_CNT + 16'd1;
  end
`else
  logic unused_ovr;
  assign unused_ovr = OVR ^ OVR_CLR;
  assign OVR_CNT    = '0;
`endif
endmodule

// File: tb/tb_adc_frontend.sv
// tb_adc_frontend: randomized scoreboard bench for adc_frontend.
// Expected OVR_CNT follows ADC_FE_OVR_CNT_EN.
`timescale 1ns/1ps
module tb_adc_frontend;
  localparam int DECIM = 4;

  logic       CLK = 1'b0, RSTN = 1'b0;
  logic       ENABLE = 1'b0, OVR = 1'b0, OVR_CLR = 1'b0;
  logic       THR_UP = 1'b0, THR_DN = 1'b0, THR_STEP = 1'b0;
  logic [9:0] WAVEX = '0;
  logic       ADCLK, PWDN, DFS, AVG_VALID, DEC_VALID, TRIG;
  logic [9:0] AVG, LLD;
  logic [15:0] OVR_CNT;

  adc_frontend #(.DECIM(DECIM)) dut (
    .CLK(CLK), .RSTN(RSTN), .WAVEX(WAVEX), .OVR(OVR),
    .ENABLE(ENABLE), .THR_UP(THR_UP), .THR_DN(THR_DN),
    .THR_STEP(THR_STEP), .OVR_CLR(OVR_CLR),
    .ADCLK(ADCLK), .PWDN(PWDN), .DFS(DFS), .AVG(AVG),
    .AVG_VALID(AVG_VALID), .DEC_VALID(DEC_VALID),
    .TRIG(TRIG), .LLD(LLD), .OVR_CNT(OVR_CNT)
  );

  always #4 CLK = ~CLK;

  typedef struct {
    int due;
    int avg;
    bit dec;
  } exp_t;

  exp_t avq[$];
  exp_t pend[$];
  int   trq[$];
  int   hist[$];
  int   e = -1;
  int   nsamp = 0, dcnt = 0;
  int   m_lld = 540, m_ovr = 0;
  bit   armed = 1'b1;
  int   n_vec = 0, n_err = 0;
  bit   mon_on = 1'b0;
`ifdef ADC_FE_OVR_CNT_EN
  localparam int OVR3 = 3;
`else
  localparam int OVR3 = 0;
`endif

  task automatic chk(string name, int act, int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)",
               name, act, exp, e);
    end
  endtask

  // reference: averages of the last 8 captures, trigger rules
  task automatic model(bit en, int w, bit ovr, bit clr,
                       bit up, bit dn, bit stp);
    int   s, stepv, lvl;
    exp_t x;
    e++;
    if (!en) begin
      avq.delete(); pend.delete(); trq.delete();
      hist.delete();
      nsamp = 0; dcnt = 0; armed = 1'b1;
    end else begin
      lvl = (m_lld > 8) ? m_lld - 8 : 0;
      while (pend.size() > 0 && pend[0].due + 1 <= e) begin
        x = pend.pop_front();
        if (armed && x.avg >= m_lld) begin
          armed = 1'b0;
          trq.push_back(e);
        end else if (!armed && x.avg < lvl) begin
          armed = 1'b1;
        end
      end
      if (e % 4 == 0) begin
        hist.push_back(w);
        if (hist.size() > 8) void'(hist.pop_front());
        nsamp++;
        if (nsamp >= 8) begin
          s = 0;
          foreach (hist[i]) s += hist[i];
          dcnt++;
          x.due = e + 2;
          x.avg = s / 8;
          x.dec = (dcnt % DECIM == 0);
          avq.push_back(x);
          pend.push_back(x);
        end
      end
    end
`ifdef ADC_FE_OVR_CNT_EN
    if (clr) m_ovr = 0;
    else if (en && e % 4 == 0 && ovr && m_ovr < 65535)
      m_ovr++;
`endif
    stepv = stp ? 32 : 4;
    if (up && !dn)
      m_lld = (m_lld + stepv > 1023) ? 1023 : m_lld + stepv;
    else if (dn && !up)
      m_lld = (m_lld < stepv) ? 0 : m_lld - stepv;
  endtask

  task automatic cyc(bit en, int w, bit ovr = 0, bit clr = 0,
                     bit up = 0, bit dn = 0, bit stp = 0);
    ENABLE = en; WAVEX = w[9:0]; OVR = ovr; OVR_CLR = clr;
    THR_UP = up; THR_DN = dn; THR_STEP = stp;
    @(posedge CLK);
    model(en, w, ovr, clr, up, dn, stp);
    @(negedge CLK);
  endtask

  // monitor: pop and compare whenever the DUT strobes
  always begin : mon
    exp_t x;
    @(posedge CLK);
    #1;
    if (mon_on) begin
      if (AVG_VALID) begin
        if (avq.size() > 0 && avq[0].due == e) begin
          x = avq.pop_front();
          chk("avg", int'(AVG), x.avg);
          chk("dec_valid", int'(DEC_VALID), int'(x.dec));
        end else begin
          chk("avg_valid_unexpected", int'(AVG_VALID), 0);
        end
      end else begin
        if (avq.size() > 0 && avq[0].due == e) begin
          void'(avq.pop_front());
          chk("avg_valid_missing", int'(AVG_VALID), 1);
        end
        chk("dec_valid_idle", int'(DEC_VALID), 0);
      end
      if (trq.size() > 0 && trq[0] == e) begin
        void'(trq.pop_front());
        chk("trig", int'(TRIG), 1);
      end else begin
        chk("trig_spurious", int'(TRIG), 0);
      end
      chk("lld", int'(LLD), m_lld);
      chk("ovr_cnt", int'(OVR_CNT), m_ovr);
      chk("adclk", int'(ADCLK), int'(((e + 1) % 4) >= 2));
      chk("pwdn", int'(PWDN), int'(!ENABLE));
      chk("dfs", int'(DFS), 0);
    end
  end

  initial begin
    #1ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_avg", int'(AVG), 0);
    chk("rst_avg_valid", int'(AVG_VALID), 0);
    chk("rst_dec_valid", int'(DEC_VALID), 0);
    chk("rst_trig", int'(TRIG), 0);
    chk("rst_lld", int'(LLD), 540);
    chk("rst_ovr_cnt", int'(OVR_CNT), 0);
    chk("rst_adclk", int'(ADCLK), 0);
    chk("rst_pwdn", int'(PWDN), 1);
    chk("rst_dfs", int'(DFS), 0);
    RSTN = 1'b1;
    mon_on = 1'b1;

    repeat (60) cyc(1, 100);
    chk("const_avg", int'(AVG), 100);
    repeat (4) cyc(0, 0);

    for (int k = 0; k < 160; k++) cyc(1, (k / 4) * 8);
    repeat (4) cyc(0, 0);

    repeat (48) cyc(1, 500);
    repeat (48) cyc(1, 600);
    repeat (48) cyc(1, 535);
    repeat (48) cyc(1, 520);
    repeat (48) cyc(1, 600);
    repeat (4) cyc(0, 0);

    repeat (14) cyc(0, 0, 0, 0, 1, 0, 1);
    repeat (3) cyc(0, 0, 0, 0, 1, 0, 0);
    chk("lld_1000", int'(LLD), 1000);
    cyc(0, 0, 0, 0, 1, 0, 1);
    chk("lld_sat_hi", int'(LLD), 1023);
    cyc(0, 0, 0, 0, 1, 1, 1);
    chk("lld_up_dn", int'(LLD), 1023);
    repeat (33) cyc(0, 0, 0, 0, 0, 1, 1);
    chk("lld_sat_lo", int'(LLD), 0);
    repeat (17) cyc(0, 0, 0, 0, 1, 0, 1);

    repeat (20) cyc(1, 200);
    repeat (3) cyc(0, 0);
    repeat (60) cyc(1, 300);

    repeat (12) cyc(1, 300, 1);
    repeat (4) cyc(1, 300, 0);
    chk("ovr_three", int'(OVR_CNT), OVR3);
    cyc(1, 300, 1, 1);
    chk("ovr_clr", int'(OVR_CNT), 0);

    for (int k = 0; k < 600; k++) begin
      bit en;
      en = ($urandom_range(0, 39) != 0);
      cyc(en, int'($urandom_range(400, 700)),
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 49) == 0,
          $urandom_range(0, 15) == 0,
          $urandom_range(0, 15) == 0,
          $urandom_range(0, 1) == 1);
    end
    repeat (4) cyc(0, 0);
    chk("drain", avq.size() + trq.size(), 0);

    cyc(0, 0, 0, 0, 1, 0, 1);
    repeat (40) cyc(1, 600, 1);
    mon_on = 1'b0;
    #1;
    RSTN = 1'b0;
    #1;
    chk("arst_avg", int'(AVG), 0);
    chk("arst_avg_valid", int'(AVG_VALID), 0);
    chk("arst_dec_valid", int'(DEC_VALID), 0);
    chk("arst_trig", int'(TRIG), 0);
    chk("arst_lld", int'(LLD), 540);
    chk("arst_ovr_cnt", int'(OVR_CNT), 0);
    chk("arst_adclk", int'(ADCLK), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/adc_frontend.md
# adc_frontend

ADC front-end stage feeding the waveform-memory recorder. It generates the AD9214 sample clock, captures 10-bit WAVEX samples, and forms an 8-sample running (boxcar) average. It emits a decimated sample strobe for memory writes and a lower-level-discriminator (LLD) trigger with USB-adjustable threshold. Everything downstream consumes AVG/DEC_VALID/TRIG instead of raw ADC pins.

## Interface
- ADC_W, 10, ADC sample width
- AVG_LOG2, 3, log2 of averaging depth (8 samples)
- DECIM, 8192, averages per decimated output (≥2)
- LLD_INIT, 540, threshold value after reset
- HYST, 8, re-arm hysteresis below LLD
- CLK  in  1  system clock, 125 MHz
- RSTN  in  1  asynchronous, active-low reset
- WAVEX  in  ADC_W  ADC data bus
- OVR  in  1  ADC overrange flag
- ENABLE  in  1  acquisition enable; low flushes the averager
- THR_UP, THR_DN  in  1 each  single-cycle threshold step requests
- THR_STEP  in  1  step size: 0 → 4, 1 → 32
- OVR_CLR  in  1  clears overrange counter
- ADCLK  out  1  ADC sample clock, CLK/4
- PWDN  out  1  ADC power-down, = ~ENABLE
- DFS  out  1  data format select, constant 0 (offset binary)
- AVG  out  ADC_W  current average
- AVG_VALID  out  1  one-cycle strobe, AVG updated
- DEC_VALID  out  1  one-cycle strobe, every DECIM-th AVG_VALID
- TRIG  out  1  one-cycle LLD crossing pulse
- LLD  out  ADC_W  current threshold
- OVR_CNT  out  16  saturating overrange count

## Operation
- Phase counter ph[1:0] free-runs from reset; ADCLK = ph[1]; sample captured when ph==0 and ENABLE=1.
- States: IDLE (ENABLE=0), FILL (fewer than 8 samples since entering), RUN. IDLE→FILL on ENABLE high; FILL→RUN after 8th capture; any state→IDLE on ENABLE low.
- Averager: 8-deep shift register plus (ADC_W+AVG_LOG2)-bit sum; per capture sum ← sum + new − oldest; AVG = sum >> AVG_LOG2 (truncate). IDLE clears taps and sum.
- AVG_VALID pulses only in RUN, including the capture that completes FILL.
- Decimator: counter 0..DECIM−1 counts AVG_VALID; DEC_VALID coincides with AVG_VALID when counter==DECIM−1, then wraps to 0. Cleared in IDLE; so first DEC_VALID is the DECIM-th average after RUN entry.
- Threshold: THR_UP adds step, THR_DN subtracts; saturates at 0 and 2^ADC_W−1; UP and DN same cycle → no change.
- Trigger: ARMED/FIRED sub-state. In ARMED, AVG_VALID with AVG ≥ LLD → TRIG pulse, go FIRED. In FIRED, AVG_VALID with AVG < LLD−HYST (floor 0) → ARMED. IDLE forces ARMED.
- OVR sampled with WAVEX; each sampled OVR=1 increments OVR_CNT, saturating at 0xFFFF; OVR_CLR wins over increment.

## Timing
- Reset values: ADCLK 0, PWDN 1, DFS 0, AVG 0, AVG_VALID 0, DEC_VALID 0, TRIG 0, LLD LLD_INIT, OVR_CNT 0; state IDLE.
- Capture at cycle N (ph==0); sum updated N+1; AVG/AVG_VALID/DEC_VALID registered at N+2; TRIG at N+3 (compares registered AVG).
- Sample period 4 CLK; strobes never adjacent.
- THR_* take effect next cycle; a trigger compare in that cycle uses the old LLD.
- ENABLE falling mid-FILL or mid-RUN: next cycle IDLE, no further strobes; in-flight strobes suppressed.
- RSTN assertion mid-operation: all outputs to reset values immediately (asynchronous).

## Configuration
- ADC_FE_OVR_CNT_EN defined: overrange counter present as above.
- Not defined: OVR and OVR_CLR ignored, OVR_CNT tied 0, counter logic removed.

## Structure
- Package adc_fe_pkg: ADC_W, AVG_LOG2, LLD_INIT, step constants (4, 32), state enum (IDLE/FILL/RUN), trigger enum (ARMED/FIRED).
- Sub-module boxcar_avg: shift taps, running sum, fill count; top holds clocking, decimator, threshold, trigger, overrange.

## Test plan
- Reset, ENABLE=1, WAVEX=100 constant → first AVG_VALID after 8th capture with AVG=100; strobes every 4 CLK.
- DECIM=4 override, ramp input 0,8,16… → DEC_VALID on 4th, 8th average; AVG=(sum of last 8)>>3.
- LLD=540, input steps 500→600 → one TRIG; drop to 535 → no re-arm; drop to 520 then back to 600 → second TRIG.
- THR_UP with THR_STEP=1 from LLD=1000 → 1023 (saturate); THR_UP+THR_DN together → unchanged; 33× THR_DN step 32 from 540 → 0.
- ENABLE low mid-FILL after 5 samples, high again → 8 fresh captures before AVG_VALID; decimator restarted.
- OVR high for 3 captures → OVR_CNT=3; OVR_CLR with OVR high same cycle → 0 (macro undefined: stays 0).
